// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Takes a length-prefixed byte stream of the form LEN_HI, LEN_LO, then 4*N data
// bytes. Each group of four bytes is packed MSB-first into a 32-bit word. Words are
// written at word addresses BASE, BASE+1, ...
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to consume a trailing XOR
// checksum byte (CHK state) that raises err on mismatch.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the current state. It never depends on in_valid.
// The source may hold in_valid low for any number of cycles; there is no timeout.
module imem_loader #(
   parameter int AW   = 11,
   parameter int BASE = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_wa,
   output logic [31:0]   imem_wd,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   words_loaded,
   output logic [2:0]    state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_CHK    = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   // Largest word count that fits between BASE and the top of the memory.
   localparam int unsigned MAX_WORDS = (1 << AW) - BASE;

   state_t      state;
   logic [15:0] len_q;      // word count N of the current load
   logic [1:0]  byte_cnt;   // data bytes already collected for the current word
   logic [23:0] asm_q;      // first three bytes of the word being assembled
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q;     // running XOR of all data bytes
`endif

   logic        take;
   logic [15:0] len_n;
   logic [AW:0] wl_next;

   assign take    = in_valid && in_ready;
   assign len_n   = {len_q[15:8], in_data};
   assign wl_next = words_loaded + 1'b1;

   // State decodes: ready in byte-accepting states, busy outside IDLE/DONE.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: in_ready = 1'b1;
         default:                           in_ready = 1'b0;
      endcase
      busy      = (state != S_IDLE) && (state != S_DONE);
      state_dbg = state;
   end

   // Load sequencer. All outputs are registered. imem_we is a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         len_q        <= '0;
         byte_cnt     <= '0;
         asm_q        <= '0;
         imem_we      <= 1'b0;
         imem_wa      <= '0;
         imem_wd      <= '0;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state        <= S_LEN_HI;
                  done         <= 1'b0;
                  err          <= 1'b0;
                  words_loaded <= '0;
                  byte_cnt     <= '0;
                  asm_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q       <= '0;
`endif
               end
            end
            S_LEN_HI: begin
               if (take) begin
                  len_q[15:8] <= in_data;
                  state       <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (take) begin
                  len_q[7:0] <= in_data;
                  if (len_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state <= S_CHK;
`else
                     state <= S_DONE;
                     done  <= 1'b1;
`endif
                  end else if ({16'd0, len_n} > MAX_WORDS) begin
                     // The load would run past the top of memory. Reject it before any write.
                     state <= S_DONE;
                     err   <= 1'b1;
                     done  <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (take) begin
                  asm_q    <= {asm_q[15:0], in_data};
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q   <= csum_q ^ in_data;
`endif
                  if (byte_cnt == 2'd3) begin
                     imem_we <= 1'b1;
                     imem_wa <= AW'(BASE) + words_loaded[AW-1:0];
                     imem_wd <= {asm_q, in_data};
                     state   <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               words_loaded <= wl_next;
               if (32'(wl_next) == 32'(len_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state <= S_CHK;
`else
                  state <= S_DONE;
                  done  <= 1'b1;
`endif
               end else begin
                  state <= S_DATA;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (take) begin
                  err   <= (in_data != csum_q);
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed, table-driven bench for imem_loader (AW=11, BASE=0).
// The bench also covers the IMEM_LOADER_CHECKSUM_EN build when that macro is defined.
module tb_imem_loader;

   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_wa;
   logic [31:0]   imem_wd;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW:0]   words_loaded;
   logic [2:0]    state_dbg;

   int total = 0;
   int bad   = 0;
   logic [AW+31:0] exp_q[$];   // expected writes: {address, data}

   imem_loader #(.AW(AW), .BASE(0)) dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
      .imem_wa(imem_wa), .imem_wd(imem_wd), .busy(busy), .done(done),
      .err(err), .words_loaded(words_loaded), .state_dbg(state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #900us;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Scoreboard: every write pulse must match the head of exp_q, and in_ready must be low.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         check("ready_low_in_write", {63'd0, in_ready}, 64'd0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got wa=%h wd=%h required no write", imem_wa, imem_wd);
         end else begin
            check("write", {21'd0, imem_wa, imem_wd}, {21'd0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- driver tasks ----------------
   // All driving happens 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap, inout logic [7:0] cs);
      for (int i = 3; i >= 0; i--) begin
         send_byte(w[8*i +: 8], gap);
         cs = cs ^ w[8*i +: 8];
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 40) begin
         total++;
         bad++;
         $display("FAIL %s_done_timeout: done=%b required 1", name, done);
      end
   endtask

   task automatic end_checks(input string name, input logic exp_err, input logic [AW:0] exp_wl);
      check({name, "_done"},  {63'd0, done},     64'd1);
      check({name, "_err"},   {63'd0, err},      {63'd0, exp_err});
      check({name, "_wl"},    {52'd0, words_loaded}, {52'd0, exp_wl});
      check({name, "_busy"},  {63'd0, busy},     64'd0);
      check({name, "_ready"}, {63'd0, in_ready}, 64'd0);
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_load(input string name, input logic [15:0] n, input int nw,
                          input logic [31:0] w0, input logic [31:0] w1, input int gap,
                          input logic exp_err, input logic [AW:0] exp_wl);
      logic [7:0] cs;
      cs = 8'h00;
      pulse_start();
      check({name, "_start_busy"},  {63'd0, busy},     64'd1);
      check({name, "_start_ready"}, {63'd0, in_ready}, 64'd1);
      check({name, "_start_clr"},   {50'd0, done, err, words_loaded}, 64'd0);
      if (!exp_err) begin
         if (nw > 0) exp_q.push_back({AW'(0), w0});
         if (nw > 1) exp_q.push_back({AW'(1), w1});
      end
      send_byte(n[15:8], gap);
      send_byte(n[7:0], gap);
      if (nw > 0) send_word(w0, gap, cs);
      if (nw > 1) send_word(w1, gap, cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!exp_err) send_byte(cs, gap);
`endif
      wait_done(name);
      end_checks(name, exp_err, exp_wl);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [15:0] n;
      int          nw;
      logic [31:0] w0;
      logic [31:0] w1;
      int          gap;
      logic        exp_err;
      logic [AW:0] exp_wl;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [7:0] cs;

      vecs[0] = '{16'h0002, 2, 32'h3C081001, 32'h8D090004, 0, 1'b0, 12'd2};
      vecs[1] = '{16'h0001, 1, 32'hDEADBEEF, 32'h00000000, 0, 1'b0, 12'd1};
      vecs[2] = '{16'h0000, 0, 32'h00000000, 32'h00000000, 0, 1'b0, 12'd0};
      vecs[3] = '{16'h0801, 0, 32'h00000000, 32'h00000000, 0, 1'b1, 12'd0};
      vecs[4] = '{16'hFFFF, 0, 32'h00000000, 32'h00000000, 0, 1'b1, 12'd0};
      vecs[5] = '{16'h0002, 2, 32'hFFFFFFFF, 32'h00000001, 2, 1'b0, 12'd2};

      // reset state
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_outputs", {26'd0, in_ready, imem_we, imem_wa, imem_wd, busy, done, err, words_loaded}, 64'd0);
      check("reset_state", {61'd0, state_dbg}, 64'd0);

      // table-driven loads
      for (int i = 0; i < 6; i++) begin
         do_load($sformatf("vec%0d", i), vecs[i].n, vecs[i].nw, vecs[i].w0, vecs[i].w1,
                 vecs[i].gap, vecs[i].exp_err, vecs[i].exp_wl);
      end

      // in_valid toggling on a 1-word load, with exact write-pulse timing
      cs = 8'h00;
      pulse_start();
      exp_q.push_back({AW'(0), 32'hA5C30F96});
      send_byte(8'h00, 1);
      send_byte(8'h01, 1);
      send_byte(8'hA5, 1); send_byte(8'hC3, 1); send_byte(8'h0F, 1);
      send_byte(8'h96, 0);
      cs = 8'hA5 ^ 8'hC3 ^ 8'h0F ^ 8'h96;
      check("tog_we_pulse", {63'd0, imem_we},  64'd1);
      check("tog_ready_low", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      check("tog_we_single", {63'd0, imem_we}, 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(cs, 0);
`else
      check("tog_done_next", {62'd0, done, busy}, 64'd2);
`endif
      wait_done("tog");
      end_checks("tog", 1'b0, 12'd1);

      // reset in the cycle after the 3rd data byte: no write, everything cleared
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
      in_data = 8'h44; in_valid = 1'b1; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      check("rst_mid_outputs", {26'd0, in_ready, imem_we, imem_wa, imem_wd, busy, done, err, words_loaded}, 64'd0);
      repeat (3) begin @(posedge clk); #1; end
      check("rst_mid_idle", {62'd0, busy, done}, 64'd0);
      do_load("after_rst", 16'h0001, 1, 32'hCAFEF00D, 32'h0, 0, 1'b0, 12'd1);

      // start pulsed while busy is ignored
      cs = 8'h00;
      pulse_start();
      exp_q.push_back({AW'(0), 32'h01234567});
      exp_q.push_back({AW'(1), 32'h89ABCDEF});
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_word(32'h01234567, 0, cs);
      pulse_start();
      check("busy_start_ignored", {61'd0, busy, done, err}, 64'd4);
      send_word(32'h89ABCDEF, 0, cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(cs, 0);
`endif
      wait_done("busy_start");
      end_checks("busy_start", 1'b0, 12'd2);

      // largest accepted load: N = 2^AW words, filling addresses 0..2047
      cs = 8'h00;
      pulse_start();
      for (int i = 0; i < 2048; i++) exp_q.push_back({AW'(i), 16'(i), ~16'(i)});
      send_byte(8'h08, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 2048; i++) send_word({16'(i), ~16'(i)}, 0, cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(cs, 0);
`endif
      wait_done("max");
      end_checks("max", 1'b0, 12'd2048);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // checksum good (11^22^33^44 = 44) and bad (45); the word is written either way
      cs = 8'h00;
      pulse_start();
      exp_q.push_back({AW'(0), 32'h11223344});
      send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_word(32'h11223344, 0, cs);
      send_byte(8'h44, 0);
      wait_done("chk_good");
      end_checks("chk_good", 1'b0, 12'd1);

      cs = 8'h00;
      pulse_start();
      exp_q.push_back({AW'(0), 32'h11223344});
      send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_word(32'h11223344, 0, cs);
      send_byte(8'h45, 0);
      wait_done("chk_bad");
      end_checks("chk_bad", 1'b1, 12'd1);
`endif

      // start in DONE after an error load clears done, err and words_loaded
      do_load("err_then", 16'h0900, 0, 32'h0, 32'h0, 0, 1'b1, 12'd0);
      do_load("clear_after_err", 16'h0001, 1, 32'h0BADC0DE, 32'h0, 1, 1'b0, 12'd1);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: accepts a length-prefixed byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instruction words, and drives a single-word write port into the instruction RAM at consecutive word addresses starting from 0. It sits between the host/debug byte source and the instruction memory's write side. This lets test programs be loaded at run time instead of from fixed image files.

## Interface
- AW, 11, word-address width of the instruction memory; maximum loadable words = 2^AW
- BASE, 0, first word address written
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE or DONE
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- imem_we  out  1  instruction-memory write enable, one-cycle pulse per word
- imem_wa  out  AW  word write address
- imem_wd  out  32  write data
- busy  out  1  load in progress (state not IDLE/DONE)
- done  out  1  load finished; held until next start or reset
- err  out  1  load failed; held until next start or reset
- words_loaded  out  AW+1  count of words written in current/last load

## Operation
- Byte accepted iff in_valid && in_ready on a clock edge.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes (MSB first per word), then optional checksum byte (see Configuration).
- States: IDLE → (start) LEN_HI → LEN_LO → DATA ⇄ WRITE → [CHK] → DONE; DONE → (start) LEN_HI.
- LEN_LO accepted: N == 0 → DONE (or CHK when enabled); N > 2^AW − BASE → err=1, DONE, no writes; else → DATA.
- DATA: shift accepted byte into 32-bit assembly register; on 4th byte → WRITE.
- WRITE: imem_we=1, imem_wa=BASE+words_loaded, imem_wd=assembled word; words_loaded increments at the end of the cycle; next state DATA if words remaining, else CHK/DONE.
- in_ready = 1 only in LEN_HI, LEN_LO, DATA, CHK.
- start while busy: ignored. start in DONE: clears done, err, and words_loaded; enters LEN_HI.
- imem_wa is an AW-bit address; BASE+N never wraps, because the overflow check rejects the load first.

## Timing
- Reset: state IDLE; in_ready=0, imem_we=0, imem_wa=0, imem_wd=0, busy=0, done=0, err=0, words_loaded=0, assembly register and checksum cleared.
- start sampled at edge k → busy=1, in_ready=1 from cycle k+1.
- 4th byte of a word accepted at edge k → imem_we=1 during cycle k+1 only; in_ready=0 during that cycle. Minimum 5 cycles per word.
- Last write (or final CHK byte) at edge k → done=1, busy=0 from cycle k+1.
- in_valid low stalls any byte-accepting state indefinitely; no timeout.
- Reset asserted mid-load (including during WRITE): next cycle all outputs at reset values; a pending write is dropped; partial RAM contents are left as written.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: after the last data byte (or after LEN_LO when N==0), state CHK accepts one byte. It is compared with the XOR of all data bytes (the length bytes are excluded). On mismatch, err=1. In all cases, done=1 afterwards; the words already written remain in RAM.
- Not defined: no CHK state and no checksum byte is consumed; err is raised only by length overflow.

## Test plan
- Reset then N=2, bytes 3C 08 10 01 | 8D 09 00 04 → imem_we pulses at wa=0 wd=3C081001, then at wa=1 wd=8D090004; done=1, words_loaded=2, err=0.
- in_valid toggled every other cycle during a 1-word load → exactly one write with the correct word; in_ready low during the WRITE cycle; no byte is lost or duplicated.
- N=0x0801 with AW=11 → err=1, done=1, no imem_we pulse, in_ready=0 after LEN_LO.
- Reset asserted in the cycle after the 3rd data byte → no write occurs; all outputs read 0 the following cycle; a subsequent start/load works normally.
- start pulsed while busy mid-load → ignored; load completes unchanged. start in DONE → done and err clear, words_loaded=0.
- With IMEM_LOADER_CHECKSUM_EN: word 11 22 33 44, checksum 44 → err=0; checksum 45 → err=1, word still written; done=1 in both cases.
